// File: rtl/insn_sequencer.sv
// Fetch/execute control FSM for the IP line: fetches opcodes, dispatches single-step
// operations to the AP counter, data counter and console port, and owns run/step/halt control.
module insn_sequencer #(
  parameter int INSN_WIDTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Run,
  input  logic                  Step,
  input  logic                  HaltRq,
  output logic                  IpRequest,
  input  logic                  IpReady,
  input  logic [INSN_WIDTH-1:0] Insn,
  output logic                  DataIsZeroed,
  output logic                  ApRequest,
  output logic                  ApDec,
  input  logic                  ApReady,
  output logic                  DataRequest,
  output logic                  DataDec,
  output logic                  DataSet,
  input  logic                  DataReady,
  input  logic                  DataZero,
  output logic                  CioOutReq,
  output logic                  CioInReq,
  input  logic                  CioAck,
  output logic                  Halted,
  output logic                  Illegal,
  output logic [CNT_WIDTH-1:0]  InsnCount
);

  typedef enum logic [3:0] {
    ST_HALTED,
    ST_FETCH,
    ST_FETCH_WAIT,
    ST_DECODE,
    ST_UNIT_ISSUE,
    ST_UNIT_SKIP,
    ST_UNIT_WAIT,
    ST_IO_OUT,
    ST_IO_IN
  } state_t;

  localparam logic [INSN_WIDTH-1:0] OP_NOP        = INSN_WIDTH'(0);
  localparam logic [INSN_WIDTH-1:0] OP_HALT       = INSN_WIDTH'(1);
  localparam logic [INSN_WIDTH-1:0] OP_INC        = INSN_WIDTH'(2);
  localparam logic [INSN_WIDTH-1:0] OP_DEC        = INSN_WIDTH'(3);
  localparam logic [INSN_WIDTH-1:0] OP_RIGHT      = INSN_WIDTH'(4);
  localparam logic [INSN_WIDTH-1:0] OP_LEFT       = INSN_WIDTH'(5);
  localparam logic [INSN_WIDTH-1:0] OP_LOOP_OPEN  = INSN_WIDTH'(6);
  localparam logic [INSN_WIDTH-1:0] OP_LOOP_CLOSE = INSN_WIDTH'(7);
  localparam logic [INSN_WIDTH-1:0] OP_OUT        = INSN_WIDTH'(8);
  localparam logic [INSN_WIDTH-1:0] OP_IN         = INSN_WIDTH'(9);

  state_t               state_q, state_d;
  logic                 fw_first_q;
  logic                 step_mode_q;
  logic                 unit_data_q;
  logic                 ap_dec_q, data_dec_q, data_set_q;
  logic                 data_is_zeroed_q;
  logic                 illegal_q;
  logic [CNT_WIDTH-1:0] insn_count_q;
  logic                 ip_request_q, ap_request_q, data_request_q;
  logic                 cio_out_req_q, cio_in_req_q, halted_q;

  logic retire, halt_insn, set_illegal, unit_done;
  logic issue, issue_data, issue_dec, issue_set;
  logic unit_ready;

  assign unit_ready = unit_data_q ? DataReady : ApReady;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    retire      = 1'b0;
    halt_insn   = 1'b0;
    set_illegal = 1'b0;
    unit_done   = 1'b0;
    issue       = 1'b0;
    issue_data  = 1'b0;
    issue_dec   = 1'b0;
    issue_set   = 1'b0;

    unique case (state_q)
      ST_HALTED: begin
        if (Run || Step) state_d = ST_FETCH;
      end
      ST_FETCH: state_d = ST_FETCH_WAIT;
      ST_FETCH_WAIT: begin
        // The IP line may still show its previous Ready in the cycle right after the request.
        if (!fw_first_q && IpReady) state_d = HaltRq ? ST_HALTED : ST_DECODE;
      end
      ST_DECODE: begin
        case (Insn)
          OP_NOP, OP_LOOP_OPEN, OP_LOOP_CLOSE: retire = 1'b1;
          OP_HALT: begin
            retire    = 1'b1;
            halt_insn = 1'b1;
          end
          OP_INC, OP_DEC: begin
            issue      = 1'b1;
            issue_data = 1'b1;
            issue_dec  = (Insn == OP_DEC);
          end
          OP_RIGHT, OP_LEFT: begin
            issue     = 1'b1;
            issue_dec = (Insn == OP_LEFT);
          end
          OP_OUT: state_d = ST_IO_OUT;
          OP_IN:  state_d = ST_IO_IN;
          default: begin
            set_illegal = 1'b1;
            state_d     = ST_HALTED;
          end
        endcase
      end
      ST_UNIT_ISSUE: state_d = ST_UNIT_SKIP;
      ST_UNIT_SKIP:  state_d = ST_UNIT_WAIT;
      ST_UNIT_WAIT: begin
        if (unit_ready) begin
          unit_done = 1'b1;
          retire    = 1'b1;
        end
      end
      ST_IO_OUT: begin
        if (CioAck) retire = 1'b1;
      end
      ST_IO_IN: begin
        if (CioAck) begin
          issue      = 1'b1;
          issue_data = 1'b1;
          issue_set  = 1'b1;
        end
      end
      default: state_d = ST_HALTED;
    endcase

    if (issue) state_d = ST_UNIT_ISSUE;
    if (retire) state_d = (halt_insn || step_mode_q || !Run || HaltRq) ? ST_HALTED : ST_FETCH;
  end

  always_ff @(posedge Clk) begin
    // NOTE: reset is synchronous, so it is tested inside the clocked block and not in the sensitivity list.
    if (!Rst_n) begin
      state_q          <= ST_HALTED;
      fw_first_q       <= 1'b0;
      step_mode_q      <= 1'b0;
      unit_data_q      <= 1'b0;
      ap_dec_q         <= 1'b0;
      data_dec_q       <= 1'b0;
      data_set_q       <= 1'b0;
      data_is_zeroed_q <= 1'b1;
      illegal_q        <= 1'b0;
      insn_count_q     <= '0;
      ip_request_q     <= 1'b0;
      ap_request_q     <= 1'b0;
      data_request_q   <= 1'b0;
      cio_out_req_q    <= 1'b0;
      cio_in_req_q     <= 1'b0;
      halted_q         <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      fw_first_q <= (state_q == ST_FETCH);

      if (state_q == ST_HALTED && state_d == ST_FETCH) step_mode_q <= ~Run;

      // Direction and Set stay put from the request until the next issue.
      if (issue) begin
        unit_data_q <= issue_data;
        if (issue_data) begin
          data_dec_q <= issue_dec;
          data_set_q <= issue_set;
        end else begin
          ap_dec_q <= issue_dec;
        end
      end

      if (unit_done) data_is_zeroed_q <= DataZero;
      if (set_illegal) illegal_q <= 1'b1;
      if (retire) insn_count_q <= insn_count_q + CNT_WIDTH'(1);

      ip_request_q   <= (state_d == ST_FETCH);
      ap_request_q   <= issue && !issue_data;
      data_request_q <= issue && issue_data;
      cio_out_req_q  <= (state_d == ST_IO_OUT);
      cio_in_req_q   <= (state_d == ST_IO_IN);
      halted_q       <= (state_d == ST_HALTED);
    end
  end

  assign IpRequest    = ip_request_q;
  assign ApRequest    = ap_request_q;
  assign ApDec        = ap_dec_q;
  assign DataRequest  = data_request_q;
  assign DataDec      = data_dec_q;
  assign DataSet      = data_set_q;
  assign CioOutReq    = cio_out_req_q;
  assign CioInReq     = cio_in_req_q;
  assign DataIsZeroed = data_is_zeroed_q;
  assign Halted       = halted_q;
  assign Illegal      = illegal_q;
  assign InsnCount    = insn_count_q;

endmodule

// File: tb/tb_insn_sequencer.sv
// Bench for insn_sequencer: behavioural IP line, counters and console around the DUT,
// a single-instruction vector table, hand-written corner sequences and random programs.
module tb_insn_sequencer;

  logic        Clk = 1'b0;
  logic        Rst_n, Run, Step, HaltRq;
  logic        IpReady, ApReady, DataReady, DataZero, CioAck;
  logic [3:0]  Insn;
  logic        IpRequest, DataIsZeroed, ApRequest, ApDec, DataRequest, DataDec, DataSet;
  logic        CioOutReq, CioInReq, Halted, Illegal;
  logic [15:0] InsnCount;

  // Narrow-counter twin sharing every input, used to see the count wrap.
  logic        w_ip_req, w_diz, w_ap_req, w_ap_dec, w_d_req, w_d_dec, w_d_set;
  logic        w_out_req, w_in_req, w_halted, w_illegal;
  logic [3:0]  w_count;

  insn_sequencer #(.INSN_WIDTH(4), .CNT_WIDTH(16)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Run(Run), .Step(Step), .HaltRq(HaltRq),
    .IpRequest(IpRequest), .IpReady(IpReady), .Insn(Insn), .DataIsZeroed(DataIsZeroed),
    .ApRequest(ApRequest), .ApDec(ApDec), .ApReady(ApReady),
    .DataRequest(DataRequest), .DataDec(DataDec), .DataSet(DataSet),
    .DataReady(DataReady), .DataZero(DataZero),
    .CioOutReq(CioOutReq), .CioInReq(CioInReq), .CioAck(CioAck),
    .Halted(Halted), .Illegal(Illegal), .InsnCount(InsnCount)
  );

  insn_sequencer #(.INSN_WIDTH(4), .CNT_WIDTH(4)) dut_w4 (
    .Clk(Clk), .Rst_n(Rst_n), .Run(Run), .Step(Step), .HaltRq(HaltRq),
    .IpRequest(w_ip_req), .IpReady(IpReady), .Insn(Insn), .DataIsZeroed(w_diz),
    .ApRequest(w_ap_req), .ApDec(w_ap_dec), .ApReady(ApReady),
    .DataRequest(w_d_req), .DataDec(w_d_dec), .DataSet(w_d_set),
    .DataReady(DataReady), .DataZero(DataZero),
    .CioOutReq(w_out_req), .CioInReq(w_in_req), .CioAck(CioAck),
    .Halted(w_halted), .Illegal(w_illegal), .InsnCount(w_count)
  );

  always #5 Clk = ~Clk;

  typedef struct packed { logic is_data; logic dec; logic set; } unit_t;

  typedef struct {
    logic [3:0] op;
    int         units;   // 0 none, 1 AP counter, 2 data counter
    logic       dec;
    logic       set;
    int         delta;
    logic       illegal;
    logic       flag;
    int         io;      // 0 none, 1 console write, 2 console read
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Environment state
  int          cyc;
  int          prog[$];
  int          pc;
  int          ip_lat, ap_lat, data_lat, cio_lat;
  int          ip_wait, ap_wait, data_wait, cio_cnt, in_hi, out_hi;
  logic        ap_dec_s, data_dec_s, data_set_s;
  logic [7:0]  mem [256];
  logic [7:0]  ap;
  logic [7:0]  pending_in;
  logic [7:0]  in_vals[$];

  // Observation logs
  unit_t       unit_log[$];
  int          ip_times[$];
  logic        flag_log[$];
  logic [7:0]  out_log[$];
  int          in_lens[$];
  int          out_lens[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_logs();
    unit_log.delete(); ip_times.delete(); flag_log.delete();
    out_log.delete(); in_lens.delete(); out_lens.delete();
  endtask

  task automatic env_clear();
    pc = 0; ip_wait = 0; ap_wait = 0; data_wait = 0; cio_cnt = 0; in_hi = 0; out_hi = 0;
    ap = 8'd0; pending_in = 8'd0;
    for (int i = 0; i < 256; i++) mem[i] = 8'd0;
    IpReady = 1'b1; ApReady = 1'b1; DataReady = 1'b1; CioAck = 1'b0; DataZero = 1'b1; Insn = 4'd0;
    ip_lat = 2; ap_lat = 2; data_lat = 2; cio_lat = 2;
    in_vals.delete();
    clear_logs();
  endtask

  // One clock: sample DUT outputs 1 time unit after the edge, then update the responders.
  task automatic tick();
    @(posedge Clk);
    #1;
    cyc++;
    if (IpRequest) begin
      ip_times.push_back(cyc);
      flag_log.push_back(DataIsZeroed);
      Insn = (pc < prog.size()) ? 4'(prog[pc]) : 4'd1;
      pc++;
      ip_wait = ip_lat;
      IpReady = 1'b0;
    end else if (ip_wait > 0) begin
      ip_wait--;
      IpReady = (ip_wait == 0);
    end

    if (ApRequest) begin
      unit_log.push_back('{1'b0, ApDec, 1'b0});
      ap_dec_s = ApDec; ap_wait = ap_lat; ApReady = 1'b0;
    end else if (ap_wait > 0) begin
      check("ap_dir_held", 32'(ApDec), 32'(ap_dec_s));
      ap_wait--;
      if (ap_wait == 0) begin
        ApReady = 1'b1;
        ap = ap_dec_s ? ap - 8'd1 : ap + 8'd1;
      end
    end

    if (DataRequest) begin
      unit_log.push_back('{1'b1, DataDec, DataSet});
      data_dec_s = DataDec; data_set_s = DataSet; data_wait = data_lat; DataReady = 1'b0;
    end else if (data_wait > 0) begin
      check("data_dir_held", 32'({DataDec, DataSet}), 32'({data_dec_s, data_set_s}));
      data_wait--;
      if (data_wait == 0) begin
        DataReady = 1'b1;
        if (data_set_s)      mem[ap] = pending_in;
        else if (data_dec_s) mem[ap] = mem[ap] - 8'd1;
        else                 mem[ap] = mem[ap] + 8'd1;
      end
    end
    DataZero = (mem[ap] == 8'd0);

    if (CioInReq || CioOutReq) begin
      cio_cnt++;
      CioAck = (cio_cnt == cio_lat);
      if (CioAck && CioInReq) pending_in = (in_vals.size() > 0) ? in_vals.pop_front() : 8'h00;
      if (CioAck && CioOutReq) out_log.push_back(mem[ap]);
    end else begin
      cio_cnt = 0;
      CioAck  = 1'b0;
    end
    if (CioInReq) in_hi++;
    else if (in_hi > 0) begin in_lens.push_back(in_hi); in_hi = 0; end
    if (CioOutReq) out_hi++;
    else if (out_hi > 0) begin out_lens.push_back(out_hi); out_hi = 0; end
  endtask

  task automatic do_reset();
    Rst_n = 1'b0; Run = 1'b0; Step = 1'b0; HaltRq = 1'b0;
    env_clear();
    tick(); tick();
    Rst_n = 1'b1;
  endtask

  // Start via Step or Run and wait (bounded) for HALTED. stop_mode 1 drops Run and
  // stop_mode 2 raises HaltRq once stop_units unit requests have been seen.
  task automatic exec(input bit use_step, input int budget, input int stop_mode, input int stop_units);
    int n;
    if (use_step) Step = 1'b1; else Run = 1'b1;
    tick();
    Step = 1'b0;
    check("started", 32'(Halted), 32'd0);
    n = 0;
    while (!Halted && n < budget) begin
      tick();
      n++;
      if (stop_mode == 1 && unit_log.size() >= stop_units) Run = 1'b0;
      if (stop_mode == 2 && unit_log.size() >= stop_units && data_wait > 0 && data_wait <= data_lat - 2)
        HaltRq = 1'b1;
    end
    Run = 1'b0;
    check("halt_reached", 32'(Halted), 32'd1);
  endtask

  task automatic load(input int p[$]);
    prog = p;
    pc = 0;
  endtask

  // Higher-level interpreter of a program: expected unit ops, flag at each fetch, outputs.
  task automatic run_random(input int iter);
    logic [7:0] rmem [256];
    logic [7:0] rap;
    logic       rflag;
    unit_t      rexp[$];
    logic       rflags[$];
    logic [7:0] routs[$];
    logic [7:0] ins[$];
    int         len, k, pick;
    int         p[$];

    do_reset();
    ip_lat = $urandom_range(2, 4); ap_lat = $urandom_range(2, 5);
    data_lat = $urandom_range(2, 5); cio_lat = $urandom_range(1, 4);
    len = $urandom_range(4, 16);
    for (int i = 0; i < len; i++) begin
      pick = $urandom_range(0, 8);
      p.push_back(pick == 0 ? 0 : pick + 1);
      if (pick + 1 == 9) ins.push_back(8'($urandom_range(0, 3)));
    end
    p.push_back(1);
    load(p);
    in_vals = ins;

    for (int i = 0; i < 256; i++) rmem[i] = 8'd0;
    rap = 8'd0; rflag = 1'b1; k = 0;
    foreach (p[i]) begin
      rflags.push_back(rflag);
      case (p[i])
        2: begin rmem[rap] = rmem[rap] + 8'd1; rexp.push_back('{1'b1, 1'b0, 1'b0}); rflag = (rmem[rap] == 0); end
        3: begin rmem[rap] = rmem[rap] - 8'd1; rexp.push_back('{1'b1, 1'b1, 1'b0}); rflag = (rmem[rap] == 0); end
        4: begin rap = rap + 8'd1; rexp.push_back('{1'b0, 1'b0, 1'b0}); rflag = (rmem[rap] == 0); end
        5: begin rap = rap - 8'd1; rexp.push_back('{1'b0, 1'b1, 1'b0}); rflag = (rmem[rap] == 0); end
        8: routs.push_back(rmem[rap]);
        9: begin rmem[rap] = ins[k]; k++; rexp.push_back('{1'b1, 1'b0, 1'b1}); rflag = (rmem[rap] == 0); end
        default: ;
      endcase
    end

    exec(1'b0, 3000, 0, 0);
    check("rnd_count", 32'(InsnCount), 32'(p.size()));
    check("rnd_illegal", 32'(Illegal), 32'd0);
    check("rnd_final_flag", 32'(DataIsZeroed), 32'(rflag));
    check("rnd_units_n", 32'(unit_log.size()), 32'(rexp.size()));
    for (int i = 0; i < rexp.size() && i < unit_log.size(); i++)
      check($sformatf("rnd%0d_unit%0d", iter, i), 32'(unit_log[i]), 32'(rexp[i]));
    check("rnd_fetch_n", 32'(flag_log.size()), 32'(rflags.size()));
    for (int i = 0; i < rflags.size() && i < flag_log.size(); i++)
      check($sformatf("rnd%0d_flag%0d", iter, i), 32'(flag_log[i]), 32'(rflags[i]));
    check("rnd_outs_n", 32'(out_log.size()), 32'(routs.size()));
    for (int i = 0; i < routs.size() && i < out_log.size(); i++)
      check($sformatf("rnd%0d_out%0d", iter, i), 32'(out_log[i]), 32'(routs[i]));
  endtask

  initial begin
    vec_t vecs[12];
    int   n;

    vecs[0]  = '{4'd0,  0, 1'b0, 1'b0, 1, 1'b0, 1'b1, 0};
    vecs[1]  = '{4'd1,  0, 1'b0, 1'b0, 1, 1'b0, 1'b1, 0};
    vecs[2]  = '{4'd2,  2, 1'b0, 1'b0, 1, 1'b0, 1'b0, 0};
    vecs[3]  = '{4'd3,  2, 1'b1, 1'b0, 1, 1'b0, 1'b0, 0};
    vecs[4]  = '{4'd4,  1, 1'b0, 1'b0, 1, 1'b0, 1'b1, 0};
    vecs[5]  = '{4'd5,  1, 1'b1, 1'b0, 1, 1'b0, 1'b1, 0};
    vecs[6]  = '{4'd6,  0, 1'b0, 1'b0, 1, 1'b0, 1'b1, 0};
    vecs[7]  = '{4'd7,  0, 1'b0, 1'b0, 1, 1'b0, 1'b1, 0};
    vecs[8]  = '{4'd8,  0, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1};
    vecs[9]  = '{4'd9,  2, 1'b0, 1'b1, 1, 1'b0, 1'b0, 2};
    vecs[10] = '{4'd12, 0, 1'b0, 1'b0, 0, 1'b1, 1'b1, 0};
    vecs[11] = '{4'd15, 0, 1'b0, 1'b0, 0, 1'b1, 1'b1, 0};

    cyc = 0;
    do_reset();
    check("rst_halted", 32'(Halted), 32'd1);
    check("rst_ipreq", 32'(IpRequest), 32'd0);
    check("rst_unitreq", 32'({ApRequest, DataRequest}), 32'd0);
    check("rst_dirs", 32'({ApDec, DataDec, DataSet}), 32'd0);
    check("rst_cio", 32'({CioOutReq, CioInReq}), 32'd0);
    check("rst_zeroed", 32'(DataIsZeroed), 32'd1);
    check("rst_illegal", 32'(Illegal), 32'd0);
    check("rst_count", 32'(InsnCount), 32'd0);

    // Single-instruction Step vectors
    foreach (vecs[v]) begin
      do_reset();
      data_lat = 4;
      in_vals.push_back(8'h2A);
      load('{int'(vecs[v].op)});
      exec(1'b1, 200, 0, 0);
      check($sformatf("v%0d_units", v), 32'(unit_log.size()), 32'(vecs[v].units != 0));
      if (vecs[v].units != 0 && unit_log.size() > 0)
        check($sformatf("v%0d_unit", v), 32'(unit_log[0]),
              32'({vecs[v].units == 2, vecs[v].dec, vecs[v].set}));
      check($sformatf("v%0d_count", v), 32'(InsnCount), 32'(vecs[v].delta));
      check($sformatf("v%0d_illegal", v), 32'(Illegal), 32'(vecs[v].illegal));
      check($sformatf("v%0d_flag", v), 32'(DataIsZeroed), 32'(vecs[v].flag));
      check($sformatf("v%0d_out", v), 32'(out_lens.size()), 32'(vecs[v].io == 1));
      check($sformatf("v%0d_in", v), 32'(in_lens.size()), 32'(vecs[v].io == 2));
      check($sformatf("v%0d_fetches", v), 32'(ip_times.size()), 32'd1);
    end

    // Minimum-latency NOP stream: one fetch every 4 cycles
    do_reset();
    load('{0, 0, 0, 1});
    exec(1'b0, 200, 0, 0);
    check("nop_count", 32'(InsnCount), 32'd4);
    check("nop_fetches", 32'(ip_times.size()), 32'd4);
    for (int i = 1; i < ip_times.size(); i++)
      check($sformatf("nop_gap%0d", i), 32'(ip_times[i] - ip_times[i-1]), 32'd4);

    // Run over > < <, dropping Run once the third AP request is out
    do_reset();
    load('{4, 5, 5});
    exec(1'b0, 300, 1, 3);
    check("ap_prog_units", 32'(unit_log.size()), 32'd3);
    for (int i = 0; i < 3 && i < unit_log.size(); i++)
      check($sformatf("ap_prog_dec%0d", i), 32'(unit_log[i]), 32'({1'b0, i != 0, 1'b0}));
    check("ap_prog_count", 32'(InsnCount), 32'd3);
    for (int i = 1; i < ip_times.size(); i++)
      check($sformatf("ap_prog_gap%0d", i), 32'(ip_times[i] - ip_times[i-1] >= 4), 32'd1);

    // Loop-close with a zero cell: no unit op, flag stays set at the following fetch
    do_reset();
    load('{7, 0, 1});
    exec(1'b0, 200, 0, 0);
    check("lc_units", 32'(unit_log.size()), 32'd0);
    check("lc_count", 32'(InsnCount), 32'd3);
    check("lc_fetches", 32'(flag_log.size()), 32'd3);
    if (flag_log.size() > 1) check("lc_flag_next", 32'(flag_log[1]), 32'd1);

    // Console read held 5 cycles, then a Set load
    do_reset();
    cio_lat = 5;
    in_vals.push_back(8'h07);
    load('{9, 1});
    exec(1'b0, 200, 0, 0);
    check("rd_len_n", 32'(in_lens.size()), 32'd1);
    if (in_lens.size() > 0) check("rd_len", 32'(in_lens[0]), 32'd5);
    check("rd_units", 32'(unit_log.size()), 32'd1);
    if (unit_log.size() > 0) check("rd_unit", 32'(unit_log[0]), 32'({1'b1, 1'b0, 1'b1}));
    check("rd_flag", 32'(DataIsZeroed), 32'd0);
    check("rd_count", 32'(InsnCount), 32'd2);

    // Console write held until acknowledge
    do_reset();
    cio_lat = 3;
    load('{2, 2, 8, 1});
    exec(1'b0, 300, 0, 0);
    check("wr_len_n", 32'(out_lens.size()), 32'd1);
    if (out_lens.size() > 0) check("wr_len", 32'(out_lens[0]), 32'd3);
    if (out_log.size() > 0) check("wr_value", 32'(out_log[0]), 32'd2);
    check("wr_count", 32'(InsnCount), 32'd4);

    // Illegal opcode: sticky across Run, cleared only by reset
    do_reset();
    load('{12});
    exec(1'b0, 200, 0, 0);
    check("ill_set", 32'(Illegal), 32'd1);
    check("ill_count", 32'(InsnCount), 32'd0);
    clear_logs();
    load('{0, 1});
    exec(1'b0, 200, 0, 0);
    check("ill_sticky", 32'(Illegal), 32'd1);
    check("ill_rerun_count", 32'(InsnCount), 32'd2);
    Rst_n = 1'b0;
    tick();
    check("ill_cleared", 32'(Illegal), 32'd0);
    Rst_n = 1'b1;

    // HaltRq in UNIT_WAIT: the op completes and retires, then HALTED
    do_reset();
    data_lat = 6;
    load('{2, 0, 0, 1});
    exec(1'b0, 200, 2, 1);
    HaltRq = 1'b0;
    check("hr_count", 32'(InsnCount), 32'd1);
    check("hr_units", 32'(unit_log.size()), 32'd1);
    check("hr_flag", 32'(DataIsZeroed), 32'd0);
    check("hr_fetches", 32'(ip_times.size()), 32'd1);

    // HaltRq honoured in FETCH_WAIT once the IP line is ready
    do_reset();
    HaltRq = 1'b1;
    load('{0});
    exec(1'b0, 200, 0, 0);
    HaltRq = 1'b0;
    check("hf_count", 32'(InsnCount), 32'd0);
    check("hf_fetches", 32'(ip_times.size()), 32'd1);

    // Counter wrap, seen on the 4-bit twin after 16 retires
    do_reset();
    load('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1});
    exec(1'b0, 400, 0, 0);
    check("wrap_main", 32'(InsnCount), 32'd16);
    check("wrap_narrow", 32'(w_count), 32'd0);

    // Reset asserted mid-operation
    do_reset();
    data_lat = 10;
    load('{2});
    Run = 1'b1;
    n = 0;
    while (!DataRequest && n < 20) begin tick(); n++; end
    check("mr_issued", 32'(DataRequest), 32'd1);
    tick(); tick();
    Rst_n = 1'b0; Run = 1'b0;
    tick();
    check("mr_halted", 32'(Halted), 32'd1);
    check("mr_reqs", 32'({IpRequest, ApRequest, DataRequest}), 32'd0);
    check("mr_count", 32'(InsnCount), 32'd0);
    check("mr_flag", 32'(DataIsZeroed), 32'd1);
    Rst_n = 1'b1;

    for (int it = 0; it < 10; it++) run_random(it);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
